// File: rtl/debug_uart_pkg.sv
// Shared definitions for the debug UART: receiver FSM state encoding,
// oversampling default and the baud divider computation (also used by the
// matching transmitter).
package debug_uart_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } rx_state_e;

    // Oversampling ticks per bit
    localparam int OVS_DEFAULT = 16;

    // Clocks per oversampling tick, truncated
    function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
        return clk_freq / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversampling tick generator. It never stalls and is never
// realigned to a frame; the receiver tolerates up to one tick of phase error.
module uart_baud_gen #(
    parameter int DIV = 162
) (
    input  logic i_clock,
    input  logic i_reset_n,
    output logic o_tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Divider counter wraps at DIV-1 and emits a one-clock tick on the wrap
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt  <= {CW{1'b0}};
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= {CW{1'b0}};
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/debug_uart_rx.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling. Feeds the
// debug unit's command byte port with one byte and a one-clock done pulse
// per correctly framed character; a zero stop bit gives a frame error pulse.
module debug_uart_rx
    import debug_uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 19_200,
    parameter int NB_DATA  = 8,
    parameter int OVS      = OVS_DEFAULT
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_done_tick,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVS);
    localparam int TW  = $clog2(OVS);
    localparam int BW  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               w_rx_s;
    logic               w_tick;

    rx_state_e          r_state;
    rx_state_e          w_state_next;
    logic [TW-1:0]      r_tick_cnt;
    logic [TW-1:0]      w_tick_cnt_next;
    logic [BW-1:0]      r_bit_cnt;
    logic [BW-1:0]      w_bit_cnt_next;
    logic [NB_DATA-1:0] r_shreg;
    logic [NB_DATA-1:0] w_shreg_next;
    logic [NB_DATA-1:0] r_rx_data;
    logic [NB_DATA-1:0] w_rx_data_next;
    logic               r_done;
    logic               w_done_next;
    logic               r_err;
    logic               w_err_next;
    logic               r_busy;

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .o_tick    (w_tick)
    );

    // Two-flop synchroniser for the asynchronous line; idle level is high
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // State, counters, shift register and registered outputs
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= {TW{1'b0}};
            r_bit_cnt  <= {BW{1'b0}};
            r_shreg    <= {NB_DATA{1'b0}};
            r_rx_data  <= {NB_DATA{1'b0}};
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shreg    <= w_shreg_next;
            r_rx_data  <= w_rx_data_next;
            r_done     <= w_done_next;
            r_err      <= w_err_next;
            r_busy     <= (w_state_next != ST_IDLE);
        end
    end

    // Next-state and datapath: the start edge is checked every clock, all
    // other decisions happen only on an oversampling tick
    always_comb begin
        w_state_next    = r_state;
        w_tick_cnt_next = r_tick_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_shreg_next    = r_shreg;
        w_rx_data_next  = r_rx_data;
        w_done_next     = 1'b0;
        w_err_next      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_state_next    = ST_START;
                    w_tick_cnt_next = {TW{1'b0}};
                end else begin
                    w_state_next    = ST_IDLE;
                end
            end

            ST_START: begin
                if (w_tick) begin
                    if (r_tick_cnt == TICK_MID) begin
                        if (!w_rx_s) begin
                            w_state_next    = ST_DATA;
                            w_tick_cnt_next = {TW{1'b0}};
                            w_bit_cnt_next  = {BW{1'b0}};
                        end else begin
                            // Line went back high before mid-start: glitch
                            w_state_next    = ST_IDLE;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + TW'(1);
                    end
                end else begin
                    w_tick_cnt_next = r_tick_cnt;
                end
            end

            ST_DATA: begin
                if (w_tick) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        // LSB arrives first, so shift in from the top
                        w_shreg_next    = {w_rx_s, r_shreg[NB_DATA-1:1]};
                        w_tick_cnt_next = {TW{1'b0}};
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_next   = ST_STOP;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + BW'(1);
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + TW'(1);
                    end
                end else begin
                    w_tick_cnt_next = r_tick_cnt;
                end
            end

            ST_STOP: begin
                if (w_tick) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        // Leave at mid-stop so a following start edge is caught
                        w_state_next = ST_IDLE;
                        if (w_rx_s) begin
                            w_rx_data_next = r_shreg;
                            w_done_next    = 1'b1;
                        end else begin
                            w_err_next     = 1'b1;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + TW'(1);
                    end
                end else begin
                    w_tick_cnt_next = r_tick_cnt;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_rx_data      = r_rx_data;
    assign o_rx_done_tick = r_done;
    assign o_frame_err    = r_err;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_debug_uart_rx.sv
// Self-checking bench for debug_uart_rx: table of frames fed through a
// scoreboard, plus hand sequences for latency, glitch, reset and break.
module tb_debug_uart_rx;

    localparam int BIT_CLKS = 160;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       done;
    logic       ferr;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int n_done = 0;
    logic prev_pulse = 1'b0;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    debug_uart_rx #(
        .CLK_FREQ (1_600_000),
        .BAUD     (10_000),
        .NB_DATA  (8),
        .OVS      (16)
    ) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_rx           (rx),
        .o_rx_data      (rx_data),
        .o_rx_done_tick (done),
        .o_frame_err    (ferr),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every done/frame_err pulse must match the queue head
    always @(negedge clk) begin
        if (rst_n && (done || ferr)) begin
            checks++;
            if (done && ferr) begin
                errors++;
                $display("FAIL pulse_overlap: done=%0b frame_err=%0b, required exclusive", done, ferr);
            end else if (prev_pulse) begin
                errors++;
                $display("FAIL pulse_spacing: pulse on consecutive clocks at cycle %0d", cyc);
            end else if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: done=%0b frame_err=%0b data=%02h, required no pulse",
                         done, ferr, rx_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.is_err != ferr || rx_data != e.data) begin
                    errors++;
                    $display("FAIL frame: got frame_err=%0b data=%02h, required frame_err=%0b data=%02h",
                             ferr, rx_data, e.is_err, e.data);
                end
            end
            if (done) begin
                last_done_cyc = cyc;
                n_done++;
            end
        end
        prev_pulse = done || ferr;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_val({name, "_data"}, 32'(rx_data), 32'h0);
        check_val({name, "_done"}, 32'(done), 32'h0);
        check_val({name, "_ferr"}, 32'(ferr), 32'h0);
        check_val({name, "_busy"}, 32'(busy), 32'h0);
    endtask

    // One 8N1 frame; a bad stop bit is held only just past its middle so the
    // receiver's re-armed start check sees an idle line afterwards
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (stop_ok) begin
            rx = 1'b1;
            repeat (BIT_CLKS) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (96) @(negedge clk);
            rx = 1'b1;
            repeat (2 * BIT_CLKS) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val({name, "_drained"}, 32'(sb_q.size()), 32'h0);
        sb_q.delete();
    endtask

    initial begin
        int c0;
        int lat;
        int done_before;
        logic saw_busy;
        logic [7:0] partial;

        vecs[0] = '{8'h01, 1'b1, 1'b0, 8'h01};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 8'h3C};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 8'h01};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{8'h0A, 1'b1, 1'b0, 8'h0A};
        vecs[5] = '{8'h5A, 1'b1, 1'b0, 8'h5A};
        vecs[6] = '{8'hA5, 1'b0, 1'b1, 8'h5A};
        vecs[7] = '{8'h00, 1'b1, 1'b0, 8'h00};
        vecs[8] = '{8'hFF, 1'b1, 1'b0, 8'hFF};

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Table: single byte, back-to-back word, bad stop bit, boundary data
        for (int i = 0; i < 9; i++) begin
            sb_q.push_back('{vecs[i].exp_err, vecs[i].exp_data});
            send_frame(vecs[i].data, vecs[i].stop_ok);
        end
        wait_drain("table");
        check_val("table_last_byte", 32'(rx_data), 32'hFF);

        // Latency from falling start edge to done pulse
        repeat (100) @(negedge clk);
        sb_q.push_back('{1'b0, 8'h01});
        c0 = cyc;
        send_frame(8'h01, 1'b1);
        wait_drain("latency");
        lat = last_done_cyc - c0;
        checks++;
        if (lat < 1512 || lat > 1530) begin
            errors++;
            $display("FAIL latency: got %0d clocks, required 1512..1530", lat);
        end

        // 48-clock glitch on an idle line
        repeat (100) @(negedge clk);
        saw_busy = 1'b0;
        c0 = cyc;
        rx = 1'b0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        rx = 1'b1;
        check_val("glitch_busy_seen", 32'(saw_busy), 32'h1);
        while (busy && (cyc - c0) < 200) @(negedge clk);
        checks++;
        if (busy || (cyc - c0) > 90) begin
            errors++;
            $display("FAIL glitch_busy_clear: busy=%0b after %0d clocks, required 0 by 90", busy, cyc - c0);
        end
        repeat (300) @(negedge clk);
        check_val("glitch_data_kept", 32'(rx_data), 32'h01);

        // Reset in the middle of data bit 4 of 0xC3
        partial = 8'hC3;
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = partial[4];
        repeat (80) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        sb_q.push_back('{1'b0, 8'h7E});
        send_frame(8'h7E, 1'b1);
        wait_drain("after_reset");
        check_val("after_reset_byte", 32'(rx_data), 32'h7E);

        // Line held low for two frame times: frame errors only, never done
        repeat (100) @(negedge clk);
        done_before = n_done;
        sb_q.push_back('{1'b1, 8'h7E});
        sb_q.push_back('{1'b1, 8'h7E});
        rx = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        check_val("break_no_done", 32'(n_done - done_before), 32'h0);
        check_val("break_both_errs", 32'(sb_q.size()), 32'h0);
        check_val("break_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("break_reset");
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        wait_drain("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
